geofence_poly: RTL and testbench

// - Streaming point-in-convex-polygon test with parametrised coordinate width and vertex count.
// - Per frame: one target point, then NUM_VERT fence vertices in any order.
// - Sorts the vertices clockwise about vertex 0 with one shared signed multiplier, then tests every edge.
// - Sits between the coordinate source and the result consumer; adds an input handshake and a reset-abort path.

---
 rtl/geofence_poly_if.sv | 19 +
 rtl/geofence_poly.sv | 182 ++++++++++++++++++
 tb/tb_geofence_poly.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/geofence_poly_if.sv
// Point/result bus for geofence_poly; carries on_edge only when GEOFENCE_EDGE_EN is defined.
interface geofence_poly_if #(
  parameter int COORD_W = 10
);
  logic [COORD_W-1:0] X;
  logic [COORD_W-1:0] Y;
  logic               in_valid;
  logic               in_ready;
  logic               valid;
  logic               is_inside;
`ifdef GEOFENCE_EDGE_EN
  logic               on_edge;
  modport master (output X, Y, in_valid, input in_ready, valid, is_inside, on_edge);
  modport slave  (input X, Y, in_valid, output in_ready, valid, is_inside, on_edge);
`else
  modport master (output X, Y, in_valid, input in_ready, valid, is_inside);
  modport slave  (input X, Y, in_valid, output in_ready, valid, is_inside);
`endif
endinterface

// File: rtl/geofence_poly.sv
// Point-in-convex-polygon test; valid 3*((N-1)(N-2)/2+N)+1 cycles after the last vertex, GEOFENCE_EDGE_EN adds on_edge.
// Backpressure: in_ready is high only in LOAD, so no point is taken from the cycle after the last vertex until after valid.
module geofence_poly #(
  parameter int COORD_W  = 10,
  parameter int NUM_VERT = 6
) (
  input  logic           clk,
  input  logic           reset_n,
  geofence_poly_if.slave bus
);
  localparam int DW = COORD_W + 1;
  localparam int PW = 2 * COORD_W + 2;
  localparam int RW = 2 * COORD_W + 3;
  localparam int IW = $clog2(NUM_VERT);
  localparam int CW = $clog2(NUM_VERT + 1);
  localparam logic [IW-1:0] LAST_V = IW'(NUM_VERT - 1);
  localparam logic [IW-1:0] LAST_I = IW'(NUM_VERT - 2);

  generate
    if (NUM_VERT < 3) begin : g_bad_num_vert
      $error("geofence_poly: NUM_VERT must be >= 3");
    end
  endgenerate

  typedef enum logic [1:0] {LOAD, SORT, TEST, DONE} state_t;
  state_t state, state_nxt;

  logic [COORD_W-1:0]   tx, ty;
  logic [COORD_W-1:0]   vx [NUM_VERT];
  logic [COORD_W-1:0]   vy [NUM_VERT];
  logic [CW-1:0]        ld_cnt;
  logic [IW-1:0]        idx_a, idx_b, idx_m, ld_idx;
  logic [1:0]           ph;
  logic signed [DW-1:0] ax_d, ay_d, bx_d, by_d, ax_q, ay_q, bx_q, by_q, mul_l, mul_r;
  logic signed [PW-1:0] mul_lx, mul_rx, prod, p1_q;
  logic signed [RW-1:0] r;
  logic                 accept, load_last, cmp_end, sort_last, test_last, r_ge, any_ge, is_inside_q;
`ifdef GEOFENCE_EDGE_EN
  logic                 r_zero, any_gt, any_eq, on_edge_q;
  assign r_zero = (r == '0);
`endif

  function automatic logic signed [DW-1:0] diff(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  assign accept    = bus.in_valid && (state == LOAD);
  assign load_last = (ld_cnt == CW'(NUM_VERT));
  assign ld_idx    = IW'(ld_cnt - CW'(1));
  assign cmp_end   = (ph == 2'd2);
  assign sort_last = (idx_a == LAST_I) && (idx_b == LAST_V);
  assign test_last = (idx_a == LAST_V);
  assign idx_m     = test_last ? '0 : idx_a + IW'(1);

  // SORT compares both vertices about V0; TEST pairs (Vk-T) with edge Vk->Vm.
  always_comb begin
    if (state == SORT) begin
      ax_d = diff(vx[idx_a], vx[0]);
      ay_d = diff(vy[idx_a], vy[0]);
      bx_d = diff(vx[idx_b], vx[0]);
      by_d = diff(vy[idx_b], vy[0]);
    end else begin
      ax_d = diff(vx[idx_a], tx);
      ay_d = diff(vy[idx_a], ty);
      bx_d = diff(vx[idx_m], vx[idx_a]);
      by_d = diff(vy[idx_m], vy[idx_a]);
    end
  end

  // One multiplier: ax*by in phase 1, bx*ay in phase 2.
  assign mul_l  = (ph == 2'd1) ? ax_q : bx_q;
  assign mul_r  = (ph == 2'd1) ? by_q : ay_q;
  assign mul_lx = {{(PW-DW){mul_l[DW-1]}}, mul_l};
  assign mul_rx = {{(PW-DW){mul_r[DW-1]}}, mul_r};
  assign prod   = mul_lx * mul_rx;
  assign r      = {p1_q[PW-1], p1_q} - {prod[PW-1], prod};
  assign r_ge   = ~r[RW-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= LOAD;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (accept && load_last)    state_nxt = SORT;
      SORT:    if (cmp_end && sort_last)   state_nxt = TEST;
      TEST:    if (cmp_end && test_last)   state_nxt = DONE;
      default:                             state_nxt = LOAD;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == LOAD);
    bus.valid     = (state == DONE);
    bus.is_inside = is_inside_q;
`ifdef GEOFENCE_EDGE_EN
    bus.on_edge   = on_edge_q;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx <= '0; ty <= '0; ld_cnt <= '0; idx_a <= '0; idx_b <= '0; ph <= '0;
      ax_q <= '0; ay_q <= '0; bx_q <= '0; by_q <= '0; p1_q <= '0;
      any_ge <= 1'b0; is_inside_q <= 1'b0;
`ifdef GEOFENCE_EDGE_EN
      any_gt <= 1'b0; any_eq <= 1'b0; on_edge_q <= 1'b0;
`endif
      for (int i = 0; i < NUM_VERT; i++) begin
        vx[i] <= '0;
        vy[i] <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          ph     <= '0;
          any_ge <= 1'b0;
`ifdef GEOFENCE_EDGE_EN
          any_gt <= 1'b0;
          any_eq <= 1'b0;
`endif
          if (accept) begin
            if (ld_cnt == '0) begin
              tx <= bus.X;
              ty <= bus.Y;
            end else begin
              vx[ld_idx] <= bus.X;
              vy[ld_idx] <= bus.Y;
            end
            ld_cnt <= load_last ? '0 : ld_cnt + CW'(1);
            if (load_last) begin
              idx_a <= IW'(1);
              idx_b <= IW'(2);
            end
          end
        end
        SORT, TEST: begin
          ph <= cmp_end ? 2'd0 : ph + 2'd1;
          if (ph == 2'd0) begin
            ax_q <= ax_d; ay_q <= ay_d; bx_q <= bx_d; by_q <= by_d;
          end
          if (ph == 2'd1) p1_q <= prod;
          if (cmp_end && state == SORT) begin
            if (r_ge) begin
              vx[idx_a] <= vx[idx_b]; vx[idx_b] <= vx[idx_a];
              vy[idx_a] <= vy[idx_b]; vy[idx_b] <= vy[idx_a];
            end
            if (sort_last) begin
              idx_a <= '0;
            end else if (idx_b == LAST_V) begin
              idx_a <= idx_a + IW'(1);
              idx_b <= idx_a + IW'(2);
            end else begin
              idx_b <= idx_b + IW'(1);
            end
          end
          if (cmp_end && state == TEST) begin
            any_ge <= any_ge | r_ge;
`ifdef GEOFENCE_EDGE_EN
            any_gt <= any_gt | (r_ge & ~r_zero);
            any_eq <= any_eq | r_zero;
`endif
            if (test_last) begin
              is_inside_q <= ~(any_ge | r_ge);
`ifdef GEOFENCE_EDGE_EN
              on_edge_q   <= ~(any_gt | (r_ge & ~r_zero)) & (any_eq | r_zero);
`endif
            end else begin
              idx_a <= idx_a + IW'(1);
            end
          end
        end
        default: begin
          idx_a <= '0;
          idx_b <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_geofence_poly.sv
// Bench for geofence_poly: directed table on N=6/4/3 instances, random frames against a reference model, mid-SORT reset.
module tb_geofence_poly;
  localparam int CW = 10;
  typedef logic [7:0][CW-1:0] pts_t;
  typedef struct packed {
    logic [1:0] u;
    logic [3:0] n;
    logic       ins;
    logic       edg;
    logic [7:0] lat;
    pts_t       px;
    pts_t       py;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n [3];
  logic [CW-1:0] dx [3];
  logic [CW-1:0] dy [3];
  logic          dv [3];
  logic          rdy [3];
  logic          vld [3];
  logic          ins [3];
  logic          edg [3];
  int checks = 0;
  int errors = 0;

  geofence_poly_if #(.COORD_W(CW)) bus6 ();
  geofence_poly_if #(.COORD_W(CW)) bus4 ();
  geofence_poly_if #(.COORD_W(CW)) bus3 ();
  geofence_poly #(.COORD_W(CW), .NUM_VERT(6)) u_dut6 (.clk(clk), .reset_n(rst_n[0]), .bus(bus6));
  geofence_poly #(.COORD_W(CW), .NUM_VERT(4)) u_dut4 (.clk(clk), .reset_n(rst_n[1]), .bus(bus4));
  geofence_poly #(.COORD_W(CW), .NUM_VERT(3)) u_dut3 (.clk(clk), .reset_n(rst_n[2]), .bus(bus3));

  assign bus6.X = dx[0]; assign bus6.Y = dy[0]; assign bus6.in_valid = dv[0];
  assign bus4.X = dx[1]; assign bus4.Y = dy[1]; assign bus4.in_valid = dv[1];
  assign bus3.X = dx[2]; assign bus3.Y = dy[2]; assign bus3.in_valid = dv[2];
  assign rdy[0] = bus6.in_ready; assign vld[0] = bus6.valid; assign ins[0] = bus6.is_inside;
  assign rdy[1] = bus4.in_ready; assign vld[1] = bus4.valid; assign ins[1] = bus4.is_inside;
  assign rdy[2] = bus3.in_ready; assign vld[2] = bus3.valid; assign ins[2] = bus3.is_inside;
`ifdef GEOFENCE_EDGE_EN
  assign edg[0] = bus6.on_edge; assign edg[1] = bus4.on_edge; assign edg[2] = bus3.on_edge;
`else
  assign edg[0] = 1'b0; assign edg[1] = 1'b0; assign edg[2] = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint cr(input longint ax, input longint ay, input longint bx, input longint by);
    return ax * by - bx * ay;
  endfunction

  // Reference: selection sort about V0 with plain integers, then the edge-sign rules.
  function automatic void model(input int n, input pts_t px, input pts_t py, output bit m_in, output bit m_edge);
    longint vx[8], vy[8], t_x, t_y, r, tmp;
    bit ge, gt, eq;
    ge = 0; gt = 0; eq = 0;
    t_x = longint'(px[0]);
    t_y = longint'(py[0]);
    for (int i = 0; i < n; i++) begin
      vx[i] = longint'(px[i+1]);
      vy[i] = longint'(py[i+1]);
    end
    for (int i = 1; i <= n - 2; i++)
      for (int j = i + 1; j < n; j++)
        if (cr(vx[i] - vx[0], vy[i] - vy[0], vx[j] - vx[0], vy[j] - vy[0]) >= 0) begin
          tmp = vx[i]; vx[i] = vx[j]; vx[j] = tmp;
          tmp = vy[i]; vy[i] = vy[j]; vy[j] = tmp;
        end
    for (int k = 0; k < n; k++) begin
      int m;
      m = (k + 1) % n;
      r = cr(vx[k] - t_x, vy[k] - t_y, vx[m] - vx[k], vy[m] - vy[k]);
      if (r >= 0) ge = 1;
      if (r > 0)  gt = 1;
      if (r == 0) eq = 1;
    end
    m_in   = !ge;
    m_edge = !gt && eq;
  endfunction

  function automatic vec_t mk(input int u, input int n, input int e_in, input int e_edge, input int lat,
                              input int tx, input int ty, input int x0, input int y0, input int x1, input int y1,
                              input int x2, input int y2, input int x3 = 0, input int y3 = 0,
                              input int x4 = 0, input int y4 = 0, input int x5 = 0, input int y5 = 0);
    vec_t v;
    v = '0;
    v.u = 2'(u); v.n = 4'(n); v.ins = 1'(e_in); v.edg = 1'(e_edge); v.lat = 8'(lat);
    v.px[0] = CW'(tx); v.px[1] = CW'(x0); v.px[2] = CW'(x1); v.px[3] = CW'(x2);
    v.px[4] = CW'(x3); v.px[5] = CW'(x4); v.px[6] = CW'(x5);
    v.py[0] = CW'(ty); v.py[1] = CW'(y0); v.py[2] = CW'(y1); v.py[3] = CW'(y2);
    v.py[4] = CW'(y3); v.py[5] = CW'(y4); v.py[6] = CW'(y5);
    return v;
  endfunction

  task automatic gen(input int n, output pts_t px, output pts_t py);
    int kind, cx, cy, rad, tmp, j, t_x, t_y;
    int xs[8], ys[8];
    px = '0; py = '0;
    kind = $urandom_range(3, 0);
    cx = $urandom_range(800, 200);
    cy = $urandom_range(800, 200);
    rad = $urandom_range(150, 10);
    for (int k = 0; k < n; k++) begin
      if (kind == 0) begin
        xs[k] = $urandom_range(1023, 0);
        ys[k] = $urandom_range(1023, 0);
      end else begin
        xs[k] = cx + $rtoi(real'(rad) * $cos(6.2831853 * real'(k) / real'(n)));
        ys[k] = cy + $rtoi(real'(rad) * $sin(6.2831853 * real'(k) / real'(n)));
      end
    end
    for (int k = n - 1; k > 0; k--) begin
      j = $urandom_range(k, 0);
      tmp = xs[k]; xs[k] = xs[j]; xs[j] = tmp;
      tmp = ys[k]; ys[k] = ys[j]; ys[j] = tmp;
    end
    if (kind == 3) begin
      j = $urandom_range(n - 1, 0);
      t_x = xs[j]; t_y = ys[j];
    end else if (kind == 0) begin
      t_x = $urandom_range(1023, 0); t_y = $urandom_range(1023, 0);
    end else begin
      t_x = cx + $urandom_range(2 * rad, 0) - rad;
      t_y = cy + $urandom_range(2 * rad, 0) - rad;
    end
    px[0] = CW'(t_x); py[0] = CW'(t_y);
    for (int k = 0; k < n; k++) begin
      px[k+1] = CW'(xs[k]);
      py[k+1] = CW'(ys[k]);
    end
  endtask

  // Loads T + n vertices with optional gaps (or in_valid held high), then checks latency, in_ready and results.
  task automatic run_frame(input int u, input int n, input pts_t px, input pts_t py, input int gap_pct,
                           input bit hold, input int exp_lat, input bit e_in, input bit e_edge, input string tag);
    int idx, budget, lat;
    bit rdy_seen, rdy_bad;
    idx = 0; budget = 0; rdy_seen = 0; rdy_bad = 0;
    dv[u] = 1'b0;
    while (idx <= n) begin
      @(negedge clk);
      if (dv[u] && rdy_seen) idx++;
      if (idx > n) break;
      budget++;
      if (budget > 4000) begin
        dv[u] = 1'b0;
        chk({tag, " load_timeout"}, idx, n + 1);
        return;
      end
      rdy_seen = rdy[u];
      if (!rdy_seen && hold) begin
        dv[u] = 1'b1; dx[u] = CW'($urandom); dy[u] = CW'($urandom);
      end else if (!hold && $urandom_range(99, 0) < gap_pct) begin
        dv[u] = 1'b0; dx[u] = CW'($urandom);
      end else begin
        dv[u] = 1'b1; dx[u] = px[idx]; dy[u] = py[idx];
      end
    end
    if (!hold) dv[u] = 1'b0;
    lat = 1;
    while (!vld[u] && lat < 300) begin
      if (rdy[u]) rdy_bad = 1;
      if (hold) begin
        dx[u] = CW'($urandom); dy[u] = CW'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    if (rdy[u]) rdy_bad = 1;
    dv[u] = 1'b0;
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " in_ready_low"}, int'(rdy_bad), 0);
    chk({tag, " is_inside"}, int'(ins[u]), int'(e_in));
`ifdef GEOFENCE_EDGE_EN
    chk({tag, " on_edge"}, int'(edg[u]), int'(e_edge));
`endif
    @(negedge clk);
    chk({tag, " valid_pulse"}, int'(vld[u]), 0);
    chk({tag, " in_ready_back"}, int'(rdy[u]), 1);
    chk({tag, " is_inside_held"}, int'(ins[u]), int'(e_in));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    pts_t px, py;
    bit m_in, m_edge;
    int nv[3];
    int u, n, cnt_v, cnt_nr;
    nv[0] = 6; nv[1] = 4; nv[2] = 3;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; dv[i] = 1'b0; dx[i] = '0; dy[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset%0d in_ready", i), int'(rdy[i]), 1);
      chk($sformatf("reset%0d valid", i), int'(vld[i]), 0);
      chk($sformatf("reset%0d is_inside", i), int'(ins[i]), 0);
`ifdef GEOFENCE_EDGE_EN
      chk($sformatf("reset%0d on_edge", i), int'(edg[i]), 0);
`endif
      rst_n[i] = 1'b1;
    end
    @(negedge clk);

    tbl[0] = mk(0, 6, 1, 0, 49, 5, 5, 8, 0, 2, 8, 0, 4, 10, 4, 2, 0, 8, 8);
    tbl[1] = mk(0, 6, 0, 0, 49, 11, 4, 8, 0, 2, 8, 0, 4, 10, 4, 2, 0, 8, 8);
    tbl[2] = mk(0, 6, 0, 1, 49, 5, 0, 8, 0, 2, 8, 0, 4, 10, 4, 2, 0, 8, 8);
    tbl[3] = mk(1, 4, 1, 0, 22, 1022, 1022, 0, 0, 1023, 1023, 1023, 0, 0, 1023);
    tbl[4] = mk(1, 4, 0, 1, 22, 0, 512, 0, 0, 1023, 1023, 1023, 0, 0, 1023);
    tbl[5] = mk(2, 3, 0, 1, 13, 3, 3, 3, 3, 9, 3, 6, 9);
    for (int t = 0; t < 6; t++)
      run_frame(int'(tbl[t].u), int'(tbl[t].n), tbl[t].px, tbl[t].py, (t % 2) * 40, t == 3,
                int'(tbl[t].lat), tbl[t].ins, tbl[t].edg, $sformatf("vec%0d", t));

    for (int f = 0; f < 30; f++) begin
      u = (f % 5 == 3) ? 1 : (f % 5 == 4) ? 2 : 0;
      n = nv[u];
      gen(n, px, py);
      model(n, px, py, m_in, m_edge);
      run_frame(u, n, px, py, (f % 3) * 25, f % 4 == 1, 3 * ((n - 1) * (n - 2) / 2 + n) + 1,
                m_in, m_edge, $sformatf("rnd%0d", f));
    end

    // Abort a frame mid-SORT with a one-cycle reset pulse.
    gen(6, px, py);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("abort load%0d in_ready", k), int'(rdy[0]), 1);
      dv[0] = 1'b1; dx[0] = px[k]; dy[0] = py[k];
    end
    @(negedge clk);
    dv[0] = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort in_sort in_ready", int'(rdy[0]), 0);
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    chk("abort is_inside_cleared", int'(ins[0]), 0);
    cnt_v = 0; cnt_nr = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (vld[0]) cnt_v++;
      if (!rdy[0]) cnt_nr++;
    end
    chk("abort no_valid", cnt_v, 0);
    chk("abort stays_load", cnt_nr, 0);
    gen(6, px, py);
    model(6, px, py, m_in, m_edge);
    run_frame(0, 6, px, py, 20, 1'b0, 49, m_in, m_edge, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
